// File: rtl/branch_pred_pkg.sv
// ============================================================================
// Module      : branch_pred_pkg
// Description : Shared constants, width helpers, counter encodings and the
//               default BTB entry layout for the branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pred_pkg;

    localparam int ENTRIES_DEFAULT = 16;
    localparam int PC_W_DEFAULT    = 32;

    function automatic int calc_idx_w(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    // Instructions are word aligned, so pc[1:0] is never part of index or tag.
    function automatic int calc_tag_w(input int entries, input int pc_w);
        return pc_w - calc_idx_w(entries) - 2;
    endfunction

    localparam int IDX_W = calc_idx_w(ENTRIES_DEFAULT);
    localparam int TAG_W = calc_tag_w(ENTRIES_DEFAULT, PC_W_DEFAULT);

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef struct packed {
        logic                    valid;
        logic [TAG_W-1:0]        tag;
        logic [PC_W_DEFAULT-1:0] target;
        logic [1:0]              ctr;
    } bp_entry_t;

endpackage

`default_nettype wire

// File: rtl/sat_counter2.sv
// ============================================================================
// Module      : sat_counter2
// Description : Next-state logic of a 2-bit saturating branch counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter2
    import branch_pred_pkg::*;
(
    input  logic [1:0] i_state,
    input  logic       i_taken,
    output logic [1:0] o_next_state
);

    always_comb begin
        o_next_state = i_state;
        if (i_taken) begin
            if (i_state != ST) begin
                o_next_state = i_state + 2'd1;
            end
        end else begin
            if (i_state != SNT) begin
                o_next_state = i_state - 2'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB with 2-bit counters, combinational lookup,
//               mispredict redirect and saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
    import branch_pred_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEFAULT,
    parameter int PC_W    = PC_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [PC_W-1:0] upd_pred_target,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_mispredicts
);

    localparam int BP_IDX_W = calc_idx_w(ENTRIES);
    localparam int BP_TAG_W = calc_tag_w(ENTRIES, PC_W);
    localparam logic [15:0] C_STAT_MAX = 16'hFFFF;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [PC_W-1:0]     target;
        logic [1:0]          ctr;
    } entry_t;

    entry_t      table_q [ENTRIES];
    entry_t      table_d [ENTRIES];
    logic [15:0] branches_q;
    logic [15:0] branches_d;
    logic [15:0] mispredicts_q;
    logic [15:0] mispredicts_d;

    logic [BP_IDX_W-1:0] w_lk_idx;
    logic [BP_TAG_W-1:0] w_lk_tag;
    entry_t              w_lk_entry;
    logic                w_lk_hit;

    logic [BP_IDX_W-1:0] w_up_idx;
    logic [BP_TAG_W-1:0] w_up_tag;
    entry_t              w_up_entry;
    logic                w_up_hit;
    logic [1:0]          w_ctr_next;
    logic                w_unused;

    // ------------------------------------------------------------------
    // Lookup reads the registered table only, so a same-cycle update at
    // the same index is not forwarded.
    // ------------------------------------------------------------------
    assign w_lk_idx   = lookup_pc[BP_IDX_W+1:2];
    assign w_lk_tag   = lookup_pc[PC_W-1:BP_IDX_W+2];
    assign w_lk_entry = table_q[w_lk_idx];
    assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

    assign pred_taken  = w_lk_hit && w_lk_entry.ctr[1];
    assign pred_target = pred_taken ? w_lk_entry.target : lookup_pc + PC_W'(4);

    assign w_up_idx   = upd_pc[BP_IDX_W+1:2];
    assign w_up_tag   = upd_pc[PC_W-1:BP_IDX_W+2];
    assign w_up_entry = table_q[w_up_idx];
    assign w_up_hit   = w_up_entry.valid && (w_up_entry.tag == w_up_tag);

    assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

    sat_counter2 u_sat_counter2 (
        .i_state      (w_up_entry.ctr),
        .i_taken      (upd_taken),
        .o_next_state (w_ctr_next)
    );

    assign redirect_valid = upd_valid &&
                            ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc    = upd_taken ? upd_target : upd_pc + PC_W'(4);

    always_comb begin
        table_d = table_q;
        if (upd_valid) begin
            if (w_up_hit) begin
                table_d[w_up_idx].ctr = w_ctr_next;
                if (upd_taken) begin
                    table_d[w_up_idx].target = upd_target;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliased into this slot.
                table_d[w_up_idx].valid  = 1'b1;
                table_d[w_up_idx].tag    = w_up_tag;
                table_d[w_up_idx].target = upd_target;
                table_d[w_up_idx].ctr    = WT;
            end
        end
    end

    always_comb begin
        branches_d    = branches_q;
        mispredicts_d = mispredicts_q;
        if (upd_valid && (branches_q != C_STAT_MAX)) begin
            branches_d = branches_q + 16'd1;
        end
        if (redirect_valid && (mispredicts_q != C_STAT_MAX)) begin
            mispredicts_d = mispredicts_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].target <= '0;
                table_q[i].ctr    <= WNT;
            end
            branches_q    <= 16'd0;
            mispredicts_q <= 16'd0;
        end else begin
            table_q       <= table_d;
            branches_q    <= branches_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign stat_branches    = branches_q;
    assign stat_mispredicts = mispredicts_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Scoreboard bench for branch_predictor against a behavioural
//               BTB model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    localparam int PC_W    = 32;
    localparam int ENTRIES = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [PC_W-1:0] lookup_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            upd_pred_taken;
    logic [PC_W-1:0] upd_pred_target;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic [15:0]     stat_branches;
    logic [15:0]     stat_mispredicts;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(ENTRIES), .PC_W(PC_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_pc        (lookup_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    // Behavioural reference model
    logic        m_valid [ENTRIES];
    logic [25:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_br;
    int          m_mp;

    typedef enum int {K_PT, K_PTGT, K_RV, K_RPC, K_SB, K_SM} kind_e;
    typedef struct {
        kind_e       kind;
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input kind_e k);
        case (k)
            K_PT:    return {31'd0, pred_taken};
            K_PTGT:  return pred_target;
            K_RV:    return {31'd0, redirect_valid};
            K_RPC:   return redirect_pc;
            K_SB:    return {16'd0, stat_branches};
            default: return {16'd0, stat_mispredicts};
        endcase
    endfunction

    task automatic push(input kind_e k, input string tag, input logic [31:0] exp);
        sb_t e;
        e.kind = k;
        e.tag  = tag;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.kind), e.exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc[31:6]);
    endfunction

    task automatic model_pred(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
        pt  = m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
        tgt = pt ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    function automatic logic model_redirect();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target)));
    endfunction

    // Applies the inputs held across the just-passed rising edge
    task automatic model_update();
        int i;
        if (rst) begin
            model_reset();
        end else if (upd_valid) begin
            i = m_idx(upd_pc);
            if (model_redirect() && m_mp < 65535) m_mp++;
            if (m_br < 65535) m_br++;
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = upd_pc[31:6];
                m_tgt[i]   = upd_target;
                m_ctr[i]   = 2;
            end
        end
    endtask

    task automatic push_comb(input string tag);
        logic        pt;
        logic [31:0] tgt;
        logic        rv;
        model_pred(lookup_pc, pt, tgt);
        push(K_PT, {tag, ".pred_taken"}, {31'd0, pt});
        push(K_PTGT, {tag, ".pred_target"}, tgt);
        rv = model_redirect();
        push(K_RV, {tag, ".redirect_valid"}, {31'd0, rv});
        if (rv) push(K_RPC, {tag, ".redirect_pc"}, upd_taken ? upd_target : upd_pc + 32'd4);
    endtask

    task automatic push_stats(input string tag);
        push(K_SB, {tag, ".stat_branches"}, m_br);
        push(K_SM, {tag, ".stat_mispredicts"}, m_mp);
    endtask

    task automatic cycle(input logic r, input logic [31:0] lk, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                         input logic upt, input logic [31:0] uptgt, input string tag);
        rst             = r;
        lookup_pc       = lk;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
        push_comb(tag);
        #2;
        drain();
        @(posedge clk);
        model_update();
        #1;
        push_stats(tag);
        drain();
    endtask

    task automatic look(input logic [31:0] pc, input string tag);
        cycle(1'b0, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, tag);
    endtask

    // Update whose recorded prediction is what the model predicts for pc
    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input string tag);
        logic        pt;
        logic [31:0] ptgt;
        model_pred(pc, pt, ptgt);
        cycle(1'b0, pc, 1'b1, pc, t, tgt, pt, ptgt, tag);
    endtask

    initial begin
        rst = 1'b1; lookup_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_stats("reset");
        drain();

        look(32'h100, "after_reset");
        cycle(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, "first_upd");
        check("first_upd.mispredicts", {16'd0, stat_mispredicts}, 32'd1);
        look(32'h100, "first_hit");
        check("first_hit.target", pred_target, 32'h200);

        for (int i = 0; i < 4; i++) upd(32'h100, 1'b1, 32'h200, $sformatf("taken%0d", i));
        upd(32'h100, 1'b0, 32'h0, "nt_from_st");
        look(32'h100, "still_taken");
        upd(32'h100, 1'b0, 32'h0, "nt_to_wnt");
        upd(32'h100, 1'b0, 32'h0, "nt_to_snt");
        look(32'h100, "now_not_taken");
        upd(32'h100, 1'b0, 32'h0, "nt_sat_low");
        upd(32'h100, 1'b1, 32'h200, "t_to_wnt");
        upd(32'h100, 1'b1, 32'h200, "t_to_wt");
        look(32'h100, "retaken");

        upd(32'h140, 1'b1, 32'h400, "alias_alloc");
        look(32'h100, "alias_old_miss");
        look(32'h140, "alias_new_hit");
        upd(32'h180, 1'b0, 32'h0, "miss_nt");
        look(32'h180, "miss_nt_no_alloc");
        upd(32'h140, 1'b0, 32'h999, "hit_nt_keep_tgt");
        upd(32'h140, 1'b1, 32'h500, "hit_t_new_tgt");
        look(32'h140, "new_target");
        upd(32'h140, 1'b1, 32'h500, "hit_t_correct");

        look(32'hFFFF_FFFC, "wrap_lookup");
        cycle(1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40, "wrap_redirect");

        cycle(1'b1, 32'h180, 1'b1, 32'h180, 1'b1, 32'h700, 1'b0, 32'h184, "rst_with_upd");
        look(32'h180, "rst_dropped_upd");
        look(32'h140, "rst_cleared");

        rst = 1'b0; lookup_pc = 32'h300; upd_valid = 1'b1; upd_pc = 32'h300;
        upd_taken = 1'b1; upd_target = 32'h800; upd_pred_taken = 1'b0; upd_pred_target = 32'h304;
        repeat (65536) begin
            @(posedge clk);
            model_update();
        end
        #1;
        push_stats("saturate");
        drain();
        check("saturate.branches_max", {16'd0, stat_branches}, 32'h0000_FFFF);
        check("saturate.mispredicts_max", {16'd0, stat_mispredicts}, 32'h0000_FFFF);
        cycle(1'b0, 32'h300, 1'b1, 32'h300, 1'b1, 32'h900, 1'b1, 32'h800, "saturate_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped BTB entries (power of two).
REQ-002 SHALL have parameter PC_W, default 32, PC width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- lookup_pc  in  PC_W  fetch PC to predict
- pred_taken  out  1  prediction for lookup_pc
- pred_target  out  PC_W  predicted next PC
- upd_valid  in  1  resolved-branch update strobe from EX
- upd_pc  in  PC_W  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  PC_W  actual branch target
- upd_pred_taken  in  1  prediction that was made for upd_pc
- upd_pred_target  in  PC_W  target that was predicted for upd_pc
- redirect_valid  out  1  mispredict: flush and refetch
- redirect_pc  out  PC_W  correct next PC
- stat_branches  out  16  resolved-branch count
- stat_mispredicts  out  16  mispredict count

Function
REQ-004 SHALL index with pc[IDX_W+1:2] (IDX_W=log2 ENTRIES); tag = pc[PC_W-1:IDX_W+2].
REQ-005 SHALL hold per entry: valid, tag, target[PC_W], 2-bit counter.
REQ-006 Lookup SHALL be combinational, same cycle: hit = valid && tag match; pred_taken = hit && counter[1]; pred_target = pred_taken ? target : lookup_pc+4.
REQ-007 Counter SHALL be saturating: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; taken increments, not-taken decrements; no wrap at 11 or 00.
REQ-008 On upd_valid with hit at upd_pc: counter updated per REQ-007; target overwritten with upd_target only when upd_taken.
REQ-009 On upd_valid with miss and upd_taken: allocate (valid=1, tag, target=upd_target, counter=10), evicting any prior occupant.
REQ-010 On upd_valid with miss and not taken: no table change.
REQ-011 Table writes SHALL take effect at the clock edge; visible to lookup the next cycle.
REQ-012 Same-cycle lookup and update to the same index: lookup SHALL return pre-update contents (no bypass).
REQ-013 redirect_valid SHALL be combinational = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
REQ-014 redirect_pc = upd_taken ? upd_target : upd_pc+4; value is don't-care when redirect_valid=0.
REQ-015 PC+4 SHALL wrap modulo 2^PC_W.
REQ-016 stat_branches SHALL increment on each upd_valid; stat_mispredicts on each redirect_valid; both saturate at 0xFFFF.

Reset
REQ-017 On rst, all entries SHALL be valid=0 with counter=01; targets and tags don't-care.
REQ-018 On rst, stat counters SHALL be 0; after reset pred_taken=0 and pred_target=lookup_pc+4.
REQ-019 rst asserted together with upd_valid: reset SHALL win and the update SHALL be dropped; redirect_valid remains combinational.

Structure
REQ-020 Package branch_pred_pkg SHALL hold ENTRIES default, IDX_W/TAG_W derivation, counter encodings (SNT, WNT, WT, ST), and the entry struct typedef.
REQ-021 The 2-bit counter update SHALL be a sub-module sat_counter2 (in: state, taken; out: next state).

Verification
REQ-022 After reset, lookup_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-023 upd 0x100 taken to 0x200, pred NT -> redirect_valid=1, redirect_pc=0x200, stat_mispredicts=1; next cycle lookup 0x100 -> pred_taken=1, pred_target=0x200.
REQ-024 Four taken updates to 0x100 then one not-taken -> counter 11 then 10, prediction remains taken; two more not-taken -> 00, pred_taken=0.
REQ-025 Alias: 0x100 allocated, then taken update at 0x140 (same index, other tag) -> lookup 0x100 misses, 0x140 hits.
REQ-026 Same-cycle lookup and first update at 0x100 -> old (miss) prediction that cycle, hit the next; rst with upd_valid -> table stays empty.
REQ-027 0x10000 updates with all mispredicts -> both stat counters hold 0xFFFF.
